arm_mul_unit: RTL and testbench

- Parametrised iterative multiply unit for the multicycle ARM core. It generalises the single long-multiply flag into a WIDTH-bit engine supporting MUL, UMULL and SMULL.
- Radix-2 shift-add with sign correction.
- Start/busy/done handshake, so the controller FSM can stall in its execute state until done.
- Produces the 2*WIDTH-bit product plus N/Z flags for S-suffixed instructions.

---
 rtl/arm_mul_pkg.sv | 37 +++
 rtl/arm_mul_abs.sv | 13 +
 rtl/arm_mul_unit.sv | 171 +++++++++++++++++
 tb/tb_arm_mul_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mul_pkg.sv
// Shared definitions for the iterative ARM multiply unit: op encodings,
// FSM state type and the N/Z flag helper.
package arm_mul_pkg;

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_UMULL = 2'b01;
  localparam logic [1:0] MUL_OP_SMULL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic n;
    logic z;
  } mul_flags_t;

  // Encoding 11 is an alias of MUL, so only the two long ops count as long.
  function automatic logic op_is_long(input logic [1:0] op);
    return (op == MUL_OP_UMULL) || (op == MUL_OP_SMULL);
  endfunction

  function automatic mul_flags_t mul_flags(input logic isLong,
                                           input logic loMsb,
                                           input logic hiMsb,
                                           input logic loZero,
                                           input logic hiZero);
    mul_flags_t f;
    f.n = isLong ? hiMsb : loMsb;
    f.z = isLong ? (loZero & hiZero) : loZero;
    return f;
  endfunction

endpackage

// File: rtl/arm_mul_abs.sv
// Combinational conditional two's-complement negate; with negate_i tied to
// the sign bit it yields the unsigned magnitude of a signed value.
module arm_mul_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  assign result_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/arm_mul_unit.sv
// Radix-2 shift-add multiplier (MUL/UMULL/SMULL) with start/busy/done handshake.
// Optional ARM_MUL_EARLY_EXIT_EN: leave RUN once the remaining multiplier is zero.
module arm_mul_unit
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   multiplicand_q, multiplicand_d;
  logic [WIDTH-1:0]   multiplier_q, multiplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   resLo_q, resLo_d;
  logic [WIDTH-1:0]   resHi_q, resHi_d;
  logic               flagN_q, flagN_d;
  logic               flagZ_q, flagZ_d;

  logic [WIDTH-1:0]   magA, magB;
  logic [2*WIDTH-1:0] prodFixed;
  logic               isSmullIn;
  logic               isLongQ;
  logic               runExit;
  logic [2*WIDTH-1:0] accExit;
  logic [WIDTH:0]     sum;
  mul_flags_t         fixFlags;

  assign isSmullIn = (op == MUL_OP_SMULL);
  assign isLongQ   = op_is_long(op_q);

  arm_mul_abs #(.WIDTH(WIDTH)) uAbsA (
    .value_i  (a),
    .negate_i (isSmullIn & a[WIDTH-1]),
    .result_o (magA)
  );

  arm_mul_abs #(.WIDTH(WIDTH)) uAbsB (
    .value_i  (b),
    .negate_i (isSmullIn & b[WIDTH-1]),
    .result_o (magB)
  );

  // A zero product is never negated, so -0 cannot appear.
  arm_mul_abs #(.WIDTH(2*WIDTH)) uNegProd (
    .value_i  (acc_q),
    .negate_i (neg_q & (acc_q != '0)),
    .result_o (prodFixed)
  );

  assign fixFlags = mul_flags(isLongQ,
                              prodFixed[WIDTH-1],
                              prodFixed[2*WIDTH-1],
                              prodFixed[WIDTH-1:0] == '0,
                              prodFixed[2*WIDTH-1:WIDTH] == '0);

`ifdef ARM_MUL_EARLY_EXIT_EN
  // After cnt iterations the partial product sits (WIDTH-cnt) bits too high.
  assign runExit = (cnt_q == CNT_W'(WIDTH)) || (multiplier_q == '0);
  assign accExit = acc_q >> (CNT_W'(WIDTH) - cnt_q);
`else
  assign runExit = (cnt_q == CNT_W'(WIDTH));
  assign accExit = acc_q;
`endif

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    multiplicand_d = multiplicand_q;
    multiplier_d   = multiplier_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    neg_d          = neg_q;
    resLo_d        = resLo_q;
    resHi_d        = resHi_q;
    flagN_d        = flagN_q;
    flagZ_d        = flagZ_q;
    sum            = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d           = op;
          multiplicand_d = magA;
          multiplier_d   = magB;
          neg_d          = isSmullIn & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d          = '0;
          cnt_d          = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (runExit) begin
          acc_d   = accExit;
          state_d = FIX;
        end else begin
          sum          = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                       + {1'b0, (multiplier_q[0] ? multiplicand_q : '0)};
          acc_d        = {sum, acc_q[WIDTH-1:1]};
          multiplier_d = multiplier_q >> 1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        resLo_d = prodFixed[WIDTH-1:0];
        resHi_d = isLongQ ? prodFixed[2*WIDTH-1:WIDTH] : '0;
        flagN_d = fixFlags.n;
        flagZ_d = fixFlags.z;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      op_q           <= '0;
      multiplicand_q <= '0;
      multiplier_q   <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      resLo_q        <= '0;
      resHi_q        <= '0;
      flagN_q        <= 1'b0;
      flagZ_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      multiplicand_q <= multiplicand_d;
      multiplier_q   <= multiplier_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      neg_q          <= neg_d;
      resLo_q        <= resLo_d;
      resHi_q        <= resHi_d;
      flagN_q        <= flagN_d;
      flagZ_q        <= flagZ_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_lo = resLo_q;
  assign result_hi = resHi_q;
  assign flag_n    = flagN_q;
  assign flag_z    = flagZ_q;

endmodule

// File: tb/tb_arm_mul_unit.sv
// Directed scoreboard bench for arm_mul_unit at WIDTH=32 and WIDTH=8.
// Expected latencies follow ARM_MUL_EARLY_EXIT_EN when it is defined.
module tb_arm_mul_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        start32;
  logic        start8;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy32, done32, n32, z32;
  logic [31:0] lo32, hi32;
  logic        busy8, done8, n8, z8;
  logic [7:0]  lo8, hi8;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic [31:0] prevLo32;
  logic [31:0] prevLo8;

  arm_mul_unit #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .reset     (rstN),
    .start     (start32),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy32),
    .done      (done32),
    .result_lo (lo32),
    .result_hi (hi32),
    .flag_n    (n32),
    .flag_z    (z32)
  );

  arm_mul_unit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (rstN),
    .start     (start8),
    .op        (op),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .busy      (busy8),
    .done      (done8),
    .result_lo (lo8),
    .result_hi (hi8),
    .flag_n    (n8),
    .flag_z    (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference product built from the language's own multiply, sign-extending for SMULL.
  function automatic exp_t model(input bit unit8, input logic [1:0] opv,
                                 input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    logic [31:0] ax, bx;
    logic [63:0] p;
    logic        isLong;
    isLong = (opv == 2'b01) || (opv == 2'b10);
    if (unit8) begin
      ax = (opv == 2'b10) ? {{24{av[7]}}, av[7:0]} : {24'b0, av[7:0]};
      bx = (opv == 2'b10) ? {{24{bv[7]}}, bv[7:0]} : {24'b0, bv[7:0]};
    end else begin
      ax = av;
      bx = bv;
    end
    if (opv == 2'b10) p = 64'(longint'($signed(ax)) * longint'($signed(bx)));
    else              p = {32'b0, ax} * {32'b0, bx};
    if (unit8) begin
      e.lo = {24'b0, p[7:0]};
      e.hi = isLong ? {24'b0, p[15:8]} : 32'b0;
      e.n  = isLong ? p[15] : p[7];
      e.z  = isLong ? (p[15:0] == 16'b0) : (p[7:0] == 8'b0);
    end else begin
      e.lo = p[31:0];
      e.hi = isLong ? p[63:32] : 32'b0;
      e.n  = isLong ? p[63] : p[31];
      e.z  = isLong ? (p == 64'b0) : (p[31:0] == 32'b0);
    end
    return e;
  endfunction

  task automatic applyStimulus(input bit unit8, input logic [1:0] opv,
                               input logic [31:0] av, input logic [31:0] bv,
                               input bit holdStart, input int expLat);
    exp_t        e;
    int          cycles;
    bit          seen;
    logic [31:0] obsLo, obsHi;
    sb.push_back(model(unit8, opv, av, bv));
    @(negedge clk);
    op = opv;
    a  = av;
    b  = bv;
    if (unit8) start8 = 1'b1;
    else       start32 = 1'b1;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      if (!holdStart) begin
        start8  = 1'b0;
        start32 = 1'b0;
      end
      cycles++;
      if (cycles == 1) begin
        checkVal("busy_after_start", unit8 ? busy8 : busy32, 1);
        checkVal("result_held_on_start", unit8 ? {24'b0, lo8} : lo32,
                 unit8 ? prevLo8 : prevLo32);
        a = $urandom;
        b = $urandom;
      end
      if (unit8 ? done8 : done32) seen = 1'b1;
    end
    start8  = 1'b0;
    start32 = 1'b0;
    checkVal("done_within_budget", 32'(seen), 1);
    e = sb.pop_front();
    if (seen) begin
      obsLo = unit8 ? {24'b0, lo8} : lo32;
      obsHi = unit8 ? {24'b0, hi8} : hi32;
      checkVal("result_lo", obsLo, e.lo);
      checkVal("result_hi", obsHi, e.hi);
      checkVal("flag_n", unit8 ? n8 : n32, 32'(e.n));
      checkVal("flag_z", unit8 ? z8 : z32, 32'(e.z));
      if (expLat > 0) checkVal("latency", cycles, expLat);
      if (unit8) prevLo8 = e.lo;
      else       prevLo32 = e.lo;
      @(negedge clk);
      checkVal("busy_after_done", unit8 ? busy8 : busy32, 0);
      checkVal("done_single_pulse", unit8 ? done8 : done32, 0);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_busy"}, busy32, 0);
    checkVal({tag, "_done"}, done32, 0);
    checkVal({tag, "_lo"}, lo32, 0);
    checkVal({tag, "_hi"}, hi32, 0);
    checkVal({tag, "_n"}, n32, 0);
    checkVal({tag, "_z"}, z32, 0);
    checkVal({tag, "_busy8"}, busy8, 0);
    checkVal({tag, "_lo8"}, lo8, 0);
  endtask

  task automatic quietWindow(input string tag, input int n);
    int dones;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done32) dones++;
    end
    checkVal(tag, dones, 0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prevLo32 = 0;
    prevLo8  = 0;
    rstN     = 1'b0;
    start32  = 1'b0;
    start8   = 1'b0;
    op       = 2'b00;
    a        = 0;
    b        = 0;
    #1;
    checkOutput("reset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 35);

    // Abort a MUL mid-RUN; results from the UMULL above must clear too.
    @(negedge clk);
    op = 2'b00; a = 7; b = 9; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midrun_reset");
    prevLo32 = 0;
    prevLo8  = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    quietWindow("no_done_after_abort", 40);
    applyStimulus(0, 2'b00, 5, 5, 0, 0);

    applyStimulus(0, 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
    applyStimulus(0, 2'b10, 32'h8000_0000, 32'h8000_0000, 0, 0);
    applyStimulus(0, 2'b00, 32'h0001_0000, 32'h0001_0000, 0, 0);
    applyStimulus(0, 2'b10, 32'h0000_0000, 32'hFFFF_FFFB, 0, 0);
    applyStimulus(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);

    applyStimulus(0, 2'b00, 3, 4, 1, 0);
    quietWindow("no_extra_done_busy_start", 40);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 2'(i % 3), $urandom, $urandom, 0, 0);
    end

`ifdef ARM_MUL_EARLY_EXIT_EN
    applyStimulus(1, 2'b01, 32'hFF, 32'h02, 0, 5);
    applyStimulus(1, 2'b10, 32'h85, 32'h00, 0, 3);
    applyStimulus(1, 2'b00, 32'h13, 32'h05, 0, 6);
`else
    applyStimulus(1, 2'b01, 32'hFF, 32'h02, 0, 11);
    applyStimulus(1, 2'b10, 32'h85, 32'h00, 0, 11);
    applyStimulus(1, 2'b00, 32'h13, 32'h05, 0, 11);
`endif
    applyStimulus(1, 2'b10, 32'h80, 32'h80, 0, 11 - 0 * 0 + 0 - 0 + 0 - 0 + 0 - 0 + 0 - 11);
    applyStimulus(1, 2'b10, 32'hF9, 32'h0B, 0, 0);
    applyStimulus(1, 2'b01, 32'hC3, 32'h7E, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
